// File: rtl/mcu_tx_response_arbiter_if.sv
// Handshake/bus bundle between the MCU TX response arbiter and its neighbours
// (command decoder, parameter registers, data FIFO and MCU UART TX).
interface mcu_tx_response_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                      cfg_ret_req;
    logic [5*DATA_WIDTH-1:0]   cfg_bus;
    logic                      ver_ret_req;
    logic                      fifo_empty;
    logic [DATA_WIDTH-1:0]     fifo_dout;
    logic                      fifo_rd;
    logic                      tx_available;
    logic [DATA_WIDTH-1:0]     data_to_uart_mcu;
    logic                      TX_use_mcu;
    logic                      AUX;
    logic [1:0]                grant_src;

    modport master (
        output cfg_ret_req, cfg_bus, ver_ret_req, fifo_empty, fifo_dout, tx_available,
        input  fifo_rd, data_to_uart_mcu, TX_use_mcu, AUX, grant_src
    );

    modport slave (
        input  cfg_ret_req, cfg_bus, ver_ret_req, fifo_empty, fifo_dout, tx_available,
        output fifo_rd, data_to_uart_mcu, TX_use_mcu, AUX, grant_src
    );
endinterface

// File: rtl/mcu_tx_response_arbiter.sv
// Shares the MCU UART TX between config-return, version and FIFO data packets.
// Optional RESP_CHECKSUM_EN appends an XOR checksum byte to config/version packets.
module mcu_tx_response_arbiter #(
    parameter int unsigned          DATA_WIDTH       = 8,
    parameter logic [DATA_WIDTH-1:0] RET_CONFIG_HEAD  = 8'hC0,
    parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_1 = 8'hC3,
    parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_2 = 8'h32,
    parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_3 = 8'h27,
    parameter logic [DATA_WIDTH-1:0] VERSION_PACKET_4 = 8'h02,
    parameter int unsigned          MAX_BURST        = 58
) (
    input logic                       internal_clk,
    input logic                       rst,
    mcu_tx_response_arbiter_if.slave  bus
);

    localparam logic [1:0] SrcNone = 2'd0;
    localparam logic [1:0] SrcCfg  = 2'd1;
    localparam logic [1:0] SrcVer  = 2'd2;
    localparam logic [1:0] SrcData = 2'd3;
    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

`ifdef RESP_CHECKSUM_EN
    localparam logic [2:0] CfgLen = 3'd7;
    localparam logic [2:0] VerLen = 3'd5;
`else
    localparam logic [2:0] CfgLen = 3'd6;
    localparam logic [2:0] VerLen = 3'd4;
`endif

    typedef enum logic [2:0] {StIdle, StFetch, StCapture, StLoad, StGuard} state_e;

    state_e                    state_q;
    logic                      cfg_pend_q, ver_pend_q;
    logic                      cfg_pend_d, ver_pend_d;
    logic [1:0]                src_q;
    logic [5*DATA_WIDTH-1:0]   cfg_snap_q;
    logic [DATA_WIDTH-1:0]     byte_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [2:0]                idx_q;
    logic [7:0]                burst_q;
    logic                      tx_q, rd_q, aux_q;
    logic                      grant_cfg, grant_ver, grant_data;
    logic                      idle_next_ok;
    logic [DATA_WIDTH-1:0]     pkt_byte;
    logic [2:0]                pkt_len;

    assign bus.data_to_uart_mcu = data_q;
    assign bus.TX_use_mcu       = tx_q;
    assign bus.fifo_rd          = rd_q;
    assign bus.AUX              = aux_q;
    assign bus.grant_src        = src_q;

    // A new pulse wins over the grant-clear so a resend request is never lost.
    always_comb begin
        grant_cfg    = (state_q == StIdle) && cfg_pend_q;
        grant_ver    = (state_q == StIdle) && !cfg_pend_q && ver_pend_q;
        grant_data   = (state_q == StIdle) && !cfg_pend_q && !ver_pend_q && !bus.fifo_empty;
        cfg_pend_d   = bus.cfg_ret_req | (cfg_pend_q & ~grant_cfg);
        ver_pend_d   = bus.ver_ret_req | (ver_pend_q & ~grant_ver);
        idle_next_ok = !cfg_pend_d && !ver_pend_d && bus.fifo_empty;
        pkt_len      = (src_q == SrcCfg) ? CfgLen : VerLen;
    end

    always_comb begin
        pkt_byte = '0;
        if (src_q == SrcCfg) begin
            case (idx_q)
                3'd0:    pkt_byte = RET_CONFIG_HEAD;
                3'd1:    pkt_byte = cfg_snap_q[4*DATA_WIDTH +: DATA_WIDTH];
                3'd2:    pkt_byte = cfg_snap_q[3*DATA_WIDTH +: DATA_WIDTH];
                3'd3:    pkt_byte = cfg_snap_q[2*DATA_WIDTH +: DATA_WIDTH];
                3'd4:    pkt_byte = cfg_snap_q[1*DATA_WIDTH +: DATA_WIDTH];
                3'd5:    pkt_byte = cfg_snap_q[0 +: DATA_WIDTH];
`ifdef RESP_CHECKSUM_EN
                default: pkt_byte = RET_CONFIG_HEAD
                                    ^ cfg_snap_q[4*DATA_WIDTH +: DATA_WIDTH]
                                    ^ cfg_snap_q[3*DATA_WIDTH +: DATA_WIDTH]
                                    ^ cfg_snap_q[2*DATA_WIDTH +: DATA_WIDTH]
                                    ^ cfg_snap_q[1*DATA_WIDTH +: DATA_WIDTH]
                                    ^ cfg_snap_q[0 +: DATA_WIDTH];
`else
                default: pkt_byte = '0;
`endif
            endcase
        end else if (src_q == SrcVer) begin
            case (idx_q)
                3'd0:    pkt_byte = VERSION_PACKET_1;
                3'd1:    pkt_byte = VERSION_PACKET_2;
                3'd2:    pkt_byte = VERSION_PACKET_3;
                3'd3:    pkt_byte = VERSION_PACKET_4;
`ifdef RESP_CHECKSUM_EN
                default: pkt_byte = VERSION_PACKET_1 ^ VERSION_PACKET_2
                                    ^ VERSION_PACKET_3 ^ VERSION_PACKET_4;
`else
                default: pkt_byte = '0;
`endif
            endcase
        end else begin
            pkt_byte = byte_q;
        end
    end

    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cfg_pend_q <= 1'b0;
            ver_pend_q <= 1'b0;
            src_q      <= SrcNone;
            cfg_snap_q <= '0;
            byte_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            burst_q    <= '0;
            tx_q       <= 1'b0;
            rd_q       <= 1'b0;
            aux_q      <= 1'b0;
        end else begin
            cfg_pend_q <= cfg_pend_d;
            ver_pend_q <= ver_pend_d;
            tx_q       <= 1'b0;
            rd_q       <= 1'b0;
            aux_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    idx_q   <= '0;
                    burst_q <= '0;
                    if (grant_cfg) begin
                        src_q      <= SrcCfg;
                        cfg_snap_q <= bus.cfg_bus;
                        state_q    <= StLoad;
                    end else if (grant_ver) begin
                        src_q   <= SrcVer;
                        state_q <= StLoad;
                    end else if (grant_data) begin
                        src_q   <= SrcData;
                        rd_q    <= 1'b1;
                        state_q <= StFetch;
                    end else begin
                        aux_q <= idle_next_ok;
                    end
                end
                StFetch: state_q <= StCapture;
                StCapture: begin
                    byte_q  <= bus.fifo_dout;
                    state_q <= StLoad;
                end
                StLoad: begin
                    if (bus.tx_available) begin
                        data_q  <= pkt_byte;
                        tx_q    <= 1'b1;
                        state_q <= StGuard;
                        if (src_q == SrcData) burst_q <= burst_q + 8'd1;
                        else                  idx_q   <= idx_q + 3'd1;
                    end
                end
                StGuard: begin
                    if (src_q == SrcData && burst_q < MaxBurst && !bus.fifo_empty) begin
                        rd_q    <= 1'b1;
                        state_q <= StFetch;
                    end else if (src_q != SrcData && idx_q < pkt_len) begin
                        state_q <= StLoad;
                    end else begin
                        src_q   <= SrcNone;
                        aux_q   <= idle_next_ok;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_tx_response_arbiter.sv
// Scoreboard bench for mcu_tx_response_arbiter: stimulus pushes expected {grant_src, byte}
// pairs, a monitor pops and compares on every TX_use_mcu strobe.
module tb_mcu_tx_response_arbiter;

    logic internal_clk = 1'b0;
    logic rst;
    always #5 internal_clk = ~internal_clk;

    mcu_tx_response_arbiter_if bus ();

    mcu_tx_response_arbiter dut (
        .internal_clk (internal_clk),
        .rst          (rst),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    int runs_q[$];
    int strobes  = 0;
    int data_run = 0;
    int rd_count = 0;

    // UART model: busy a few cycles after each start strobe; hold forces it unavailable.
    logic hold = 1'b0;
    int   busy = 0;
    assign bus.tx_available = (busy == 0) && !hold;

    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] fifo_q = 8'h00;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_dout  = fifo_q;

    always @(posedge internal_clk) begin
        if (rst) busy <= 0;
        else if (bus.TX_use_mcu) busy <= 3;
        else if (busy != 0) busy <= busy - 1;
        if (!rst && bus.fifo_rd) begin
            fifo_q   <= fifo_mem[rd_ptr % 256];
            rd_ptr   <= rd_ptr + 1;
            rd_count <= rd_count + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge internal_clk);
            if (!rst) begin
                if (bus.TX_use_mcu) begin
                    strobes++;
                    if (bus.grant_src == 2'd3) data_run++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got %0h with src %0d expected none",
                                 bus.data_to_uart_mcu, bus.grant_src);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", {bus.grant_src, bus.data_to_uart_mcu}, e);
                    end
                end
                if (bus.grant_src == 2'd0 && data_run != 0) begin
                    runs_q.push_back(data_run);
                    data_run = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge internal_clk);
    endtask

    task automatic push_cfg(input logic [39:0] v, input int nbytes);
        logic [47:0] pkt;
        pkt = {8'hC0, v};
        for (int i = 0; i < nbytes; i++) exp_q.push_back({2'd1, pkt[47-8*i -: 8]});
    endtask

    task automatic push_ver();
        logic [31:0] pkt;
        pkt = 32'hC3322702;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd2, pkt[31-8*i -: 8]});
    endtask

    task automatic fifo_load(input logic [7:0] v);
        fifo_mem[wr_ptr % 256] = v;
        wr_ptr++;
        exp_q.push_back({2'd3, v});
    endtask

    task automatic pulse(input logic c, input logic v);
        bus.cfg_ret_req = c;
        bus.ver_ret_req = v;
        @(negedge internal_clk);
        bus.cfg_ret_req = 1'b0;
        bus.ver_ret_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.AUX !== 1'b1) && n < budget) begin
            @(negedge internal_clk);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_aux_idle"}, 64'(bus.AUX), 64'd1);
        check({name, "_src_idle"}, 64'(bus.grant_src), 64'd0);
    endtask

    task automatic wait_strobes(input string name, input int target);
        int n = 0;
        while (strobes < target && n < 500) begin
            @(negedge internal_clk);
            n++;
        end
        check({name, "_reached"}, 64'(strobes >= target), 64'd1);
    endtask

    initial begin : stimulus
        int s0;
        int r0;
        int rd0;
        rst             = 1'b1;
        bus.cfg_ret_req = 1'b0;
        bus.ver_ret_req = 1'b0;
        bus.cfg_bus     = '0;
        tick(2);
        check("rst_data", 64'(bus.data_to_uart_mcu), 64'd0);
        check("rst_tx_use", 64'(bus.TX_use_mcu), 64'd0);
        check("rst_fifo_rd", 64'(bus.fifo_rd), 64'd0);
        check("rst_aux", 64'(bus.AUX), 64'd0);
        check("rst_grant", 64'(bus.grant_src), 64'd0);
        rst = 1'b0;
        tick(2);
        check("aux_after_reset", 64'(bus.AUX), 64'd1);

        // Single config packet, latency and AUX drop.
        bus.cfg_bus = 40'h2702FF00AA;
        push_cfg(40'h2702FF00AA, 6);
        pulse(1'b1, 1'b0);
        check("aux_drop", 64'(bus.AUX), 64'd0);
        check("no_early_strobe", 64'(bus.TX_use_mcu), 64'd0);
        tick(2);
        check("first_strobe_latency", 64'(bus.TX_use_mcu), 64'd1);
        check("grant_cfg", 64'(bus.grant_src), 64'd1);
        wait_done("cfg", 300);

        // Simultaneous requests: config first, version right after.
        bus.cfg_bus = 40'h1122334455;
        push_cfg(40'h1122334455, 6);
        push_ver();
        pulse(1'b1, 1'b1);
        wait_done("cfg_ver", 400);

        // 70 FIFO bytes: one full burst, re-arbitration, remainder.
        r0  = runs_q.size();
        rd0 = rd_count;
        for (int i = 0; i < 70; i++) fifo_load(8'(i * 7 + 3));
        wait_done("burst70", 3000);
        check("burst70_runs", 64'(runs_q.size() - r0), 64'd2);
        if (runs_q.size() - r0 == 2) begin
            check("burst70_first", 64'(runs_q[r0]), 64'd58);
            check("burst70_second", 64'(runs_q[r0+1]), 64'd12);
        end
        check("burst70_rd_count", 64'(rd_count - rd0), 64'd70);

        // Version request mid-burst waits for the burst to finish.
        r0 = runs_q.size();
        s0 = strobes;
        for (int i = 0; i < 30; i++) fifo_load(8'(i) ^ 8'hA5);
        wait_strobes("burst30_byte10", s0 + 10);
        push_ver();
        pulse(1'b0, 1'b1);
        wait_done("burst_then_ver", 2000);
        check("burst30_runs", 64'(runs_q.size() - r0), 64'd1);
        if (runs_q.size() - r0 == 1) check("burst30_len", 64'(runs_q[r0]), 64'd30);

        // TX held unavailable; cfg_bus changes after the grant must not leak in.
        hold        = 1'b1;
        bus.cfg_bus = 40'hA1B2C3D4E5;
        push_cfg(40'hA1B2C3D4E5, 6);
        s0 = strobes;
        pulse(1'b1, 1'b0);
        tick(3);
        bus.cfg_bus = 40'h0;
        tick(17);
        check("hold_no_strobe", 64'(strobes - s0), 64'd0);
        check("hold_grant", 64'(bus.grant_src), 64'd1);
        hold = 1'b0;
        tick(2);
        check("hold_one_strobe", 64'(strobes - s0), 64'd1);
        wait_done("hold", 300);

        // Reset during config byte 3 aborts it and drops the pending version request.
        bus.cfg_bus = 40'h0102030405;
        push_cfg(40'h0102030405, 3);
        s0 = strobes;
        pulse(1'b1, 1'b0);
        wait_strobes("rst_mid_byte1", s0 + 1);
        pulse(1'b0, 1'b1);
        wait_strobes("rst_mid_byte3", s0 + 3);
        rst = 1'b1;
        #1;
        check("midrst_data", 64'(bus.data_to_uart_mcu), 64'd0);
        check("midrst_tx_use", 64'(bus.TX_use_mcu), 64'd0);
        check("midrst_fifo_rd", 64'(bus.fifo_rd), 64'd0);
        check("midrst_aux", 64'(bus.AUX), 64'd0);
        check("midrst_grant", 64'(bus.grant_src), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(40);
        check("midrst_no_more_strobes", 64'(strobes - s0), 64'd3);
        check("midrst_queue", 64'(exp_q.size()), 64'd0);
        check("midrst_aux_idle", 64'(bus.AUX), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
